// File: rtl/parity_frame_checker.sv
// Serial frame parity checker: DATA_BITS data bits LSB first plus one parity bit.
// Keeps a Mealy running-parity output and a saturating frame error count.
module parity_frame_checker #(
   parameter int DATA_BITS = 8,
   parameter int ERR_CNT_W = 8,
   parameter int CNT_W     = $clog2(DATA_BITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_bit,
   input  logic                 odd_mode,
   input  logic                 clr_cnt,
   output logic                 par_run,
   output logic                 frame_done,
   output logic                 frame_err,
   output logic [DATA_BITS-1:0] data_out,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic {
      ST_DATA,
      ST_PARITY
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 r_par;
   logic                 w_par_nxt;
   logic                 r_mode;
   logic                 w_mode_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 r_err;
   logic                 w_err_nxt;
   logic [DATA_BITS-1:0] r_dout;
   logic [DATA_BITS-1:0] w_dout_nxt;
   logic [ERR_CNT_W-1:0] r_ecnt;
   logic [ERR_CNT_W-1:0] w_ecnt_base;
   logic [ERR_CNT_W-1:0] w_ecnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_DATA;
         r_cnt   <= '0;
         r_par   <= 1'b0;
         r_mode  <= 1'b0;
         r_shift <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_dout  <= '0;
         r_ecnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_par   <= w_par_nxt;
         r_mode  <= w_mode_nxt;
         r_shift <= w_shift_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_dout  <= w_dout_nxt;
         r_ecnt  <= w_ecnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_par_nxt   = r_par;
      w_mode_nxt  = r_mode;
      w_shift_nxt = r_shift;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_dout_nxt  = r_dout;
      case (r_state)
         ST_DATA: begin
            if (in_valid) begin
               if (r_cnt == '0) w_mode_nxt = odd_mode;
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (r_cnt == CNT_W'(i)) w_shift_nxt[i] = in_bit;
               end
               w_par_nxt = r_par ^ in_bit;
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DATA_BITS - 1)) w_state_nxt = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (in_valid) begin
               // error when total ones parity differs from the latched mode
               w_err_nxt   = r_par ^ in_bit ^ r_mode;
               w_done_nxt  = 1'b1;
               w_dout_nxt  = r_shift;
               w_cnt_nxt   = '0;
               w_par_nxt   = 1'b0;
               w_state_nxt = ST_DATA;
            end
         end
         default: w_state_nxt = ST_DATA;
      endcase
   end

   // clear first, then count, so a clear on an erroring frame yields 1
   always_comb begin
      w_ecnt_base = clr_cnt ? '0 : r_ecnt;
      w_ecnt_nxt  = w_ecnt_base;
      if (w_done_nxt && w_err_nxt && (w_ecnt_base != '1))
         w_ecnt_nxt = w_ecnt_base + ERR_CNT_W'(1);
   end

   assign par_run    = r_par ^ (in_valid & in_bit);
   assign frame_done = r_done;
   assign frame_err  = r_err;
   assign data_out   = r_dout;
   assign err_cnt    = r_ecnt;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised and directed bench for parity_frame_checker against a frame-level model.
// Two instances share stimulus: default counter width and a 2-bit counter.
module tb_parity_frame_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       odd_mode = 1'b0;
   logic       clr_cnt = 1'b0;
   logic       par_run_a, done_a, err_a;
   logic [7:0] dout_a, ecnt_a;
   logic       par_run_b, done_b, err_b;
   logic [7:0] dout_b;
   logic [1:0] ecnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   bit         q[$];
   bit         m_mode;
   bit         m_done, m_err;
   logic [7:0] m_dout;
   int         m_c8, m_c2;

   always #5 clk = ~clk;

   parity_frame_checker #(.DATA_BITS(8), .ERR_CNT_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .odd_mode(odd_mode), .clr_cnt(clr_cnt), .par_run(par_run_a),
      .frame_done(done_a), .frame_err(err_a), .data_out(dout_a),
      .err_cnt(ecnt_a)
   );

   parity_frame_checker #(.DATA_BITS(8), .ERR_CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .odd_mode(odd_mode), .clr_cnt(clr_cnt), .par_run(par_run_b),
      .frame_done(done_b), .frame_err(err_b), .data_out(dout_b),
      .err_cnt(ecnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ones_in_q();
      int n = 0;
      foreach (q[i]) n += q[i];
      return n;
   endfunction

   task automatic chk_outputs();
      chk("done_a", 32'(done_a), 32'(m_done));
      chk("done_b", 32'(done_b), 32'(m_done));
      chk("err_a", 32'(err_a), 32'(m_err));
      chk("err_b", 32'(err_b), 32'(m_err));
      chk("dout_a", 32'(dout_a), 32'(m_dout));
      chk("dout_b", 32'(dout_b), 32'(m_dout));
      chk("ecnt_a", 32'(ecnt_a), 32'(m_c8));
      chk("ecnt_b", 32'(ecnt_b), 32'(m_c2));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      clr_cnt = 1'b0;
      @(posedge clk);
      q.delete();
      m_mode = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_dout = 8'h00;
      m_c8 = 0;
      m_c2 = 0;
      #1 chk_outputs();
   endtask

   task automatic cycle(input bit v, input bit b, input bit m, input bit c);
      int ones;
      bit fe;
      @(negedge clk);
      rst = 1'b0;
      in_valid = v;
      in_bit = b;
      odd_mode = m;
      clr_cnt = c;
      #1;
      chk("par_run_a", 32'(par_run_a), 32'((ones_in_q() + int'(v & b)) % 2));
      chk("par_run_b", 32'(par_run_b), 32'((ones_in_q() + int'(v & b)) % 2));
      @(posedge clk);
      m_done = 1'b0;
      fe = 1'b0;
      if (v) begin
         q.push_back(b);
         if (q.size() == 1) m_mode = m;
         if (q.size() == 9) begin
            m_dout = 8'h00;
            for (int i = 0; i < 8; i++) m_dout += 8'(int'(q[i]) << i);
            ones = ones_in_q();
            fe = ((ones % 2) == 1) != m_mode;
            m_done = 1'b1;
            m_err = fe;
            q.delete();
         end
      end
      if (c) begin
         m_c8 = 0;
         m_c2 = 0;
      end
      if (fe) begin
         m_c8 = (m_c8 == 255) ? 255 : m_c8 + 1;
         m_c2 = (m_c2 == 3) ? 3 : m_c2 + 1;
      end
      #1 chk_outputs();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit p, input bit m0,
                             input bit m1, input int stall, input bit c_last);
      for (int i = 0; i < 9; i++) begin
         for (int s = 0; s < stall; s++) cycle(1'b0, 1'b1, m1, 1'b0);
         cycle(1'b1, (i < 8) ? d[i] : p, (i == 0) ? m0 : m1,
               (i == 8) ? c_last : 1'b0);
      end
   endtask

   initial begin
      logic [7:0] d;
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h07, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 3, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_frame(8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      for (int f = 0; f < 60; f++) begin
         d = 8'($urandom);
         send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i < $urandom_range(1, 8); i++)
               cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            do_reset();
         end
      end
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 40) == 0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
